// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped fetch-stage BTB with 2-bit direction counters,
//               zero-latency lookup and RAS-sourced return targets.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter  int XLEN      = 32,
    parameter  int N_ENTRIES = 64,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] ras_address,
    input  logic            ras_empty,
    output logic            hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predicted_pc,
    output logic [1:0]      predicted_type,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic [1:0]      update_type
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] c_type_cond   = 2'd0;
    localparam logic [1:0] c_type_return = 2'd2;
    localparam logic [1:0] c_ctr_max     = 2'd3;
    localparam logic [1:0] c_ctr_alloc   = 2'd2;

    logic              r_valid  [N_ENTRIES];
    logic [TAG_W-1:0]  r_tag    [N_ENTRIES];
    logic [XLEN-1:0]   r_target [N_ENTRIES];
    logic [1:0]        r_type   [N_ENTRIES];
    logic [1:0]        r_ctr    [N_ENTRIES];

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [TAG_W-1:0]  w_fetch_tag;
    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;
    logic              w_upd_match;
    logic [XLEN-1:0]   w_taken_pc;
    logic              w_unused_pc_lsb;

    assign w_fetch_idx     = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag     = fetch_pc[XLEN-1:IDX_W+2];
    assign w_upd_idx       = update_pc[IDX_W+1:2];
    assign w_upd_tag       = update_pc[XLEN-1:IDX_W+2];
    assign w_upd_match     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_unused_pc_lsb = ^update_pc[1:0];

    // Gating with reset keeps stale contents invisible until the clearing edge.
    always_comb begin
        hit            = reset && r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
        predict_taken  = hit && ((r_type[w_fetch_idx] != c_type_cond) || r_ctr[w_fetch_idx][1]);
        predicted_type = hit ? r_type[w_fetch_idx] : 2'd0;
        if ((r_type[w_fetch_idx] == c_type_return) && !ras_empty) begin
            w_taken_pc = ras_address;
        end else begin
            w_taken_pc = r_target[w_fetch_idx];
        end
        predicted_pc = predict_taken ? w_taken_pc : (fetch_pc + XLEN'(4));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_type[i]   <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (update_valid) begin
            if (w_upd_match) begin
                r_type[w_upd_idx] <= update_type;
                if (update_taken) begin
                    r_target[w_upd_idx] <= update_target;
                    if (r_ctr[w_upd_idx] != c_ctr_max) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                    end
                end else if (r_ctr[w_upd_idx] != 2'd0) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Only taken outcomes allocate; an alias is simply overwritten.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= update_target;
                r_type[w_upd_idx]   <= update_type;
                r_ctr[w_upd_idx]    <= c_ctr_alloc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed self-checking bench for branch_target_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic [31:0] ras_address;
    logic        ras_empty;
    logic        hit;
    logic        predict_taken;
    logic [31:0] predicted_pc;
    logic [1:0]  predicted_type;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [1:0]  update_type;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [1:0]  ty;
    } exp_t;

    exp_t sb[$];

    branch_target_buffer #(.XLEN(32), .N_ENTRIES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .ras_address    (ras_address),
        .ras_empty      (ras_empty),
        .hit            (hit),
        .predict_taken  (predict_taken),
        .predicted_pc   (predicted_pc),
        .predicted_type (predicted_type),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .update_type    (update_type)
    );

    always #5 clk = ~clk;

    // Drive a fetch PC, queue the expected prediction, let it settle, then compare.
    task automatic look(input string name, input logic [31:0] pc, input logic e_hit,
                        input logic e_taken, input logic [31:0] e_pc, input logic [1:0] e_ty);
        exp_t e;
        fetch_pc = pc;
        e.name = name; e.hit = e_hit; e.taken = e_taken; e.pc = e_pc; e.ty = e_ty;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        checks++;
        assert (hit === e.hit) else begin
            failures++;
            $error("FAIL %s.hit observed=%b expected=%b", e.name, hit, e.hit);
        end
        checks++;
        assert (predict_taken === e.taken) else begin
            failures++;
            $error("FAIL %s.taken observed=%b expected=%b", e.name, predict_taken, e.taken);
        end
        checks++;
        assert (predicted_pc === e.pc) else begin
            failures++;
            $error("FAIL %s.pc observed=%h expected=%h", e.name, predicted_pc, e.pc);
        end
        checks++;
        assert (predicted_type === e.ty) else begin
            failures++;
            $error("FAIL %s.type observed=%0d expected=%0d", e.name, predicted_type, e.ty);
        end
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic [1:0] ty);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = taken;
        update_type   = ty;
        @(posedge clk); #1;
        update_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; fetch_pc = 32'h0; ras_address = 32'h0; ras_empty = 1'b1;
        update_valid = 1'b0; update_pc = 32'h0; update_target = 32'h0;
        update_taken = 1'b0; update_type = 2'd0;
        @(posedge clk); #1;
        look("in_reset", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        look("after_reset", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);

        // Allocation and counter walk for a conditional branch at 0x100.
        train(32'h100, 32'h200, 1'b1, 2'd0);
        look("alloc_ctr2", 32'h100, 1'b1, 1'b1, 32'h200, 2'd0);
        train(32'h100, 32'hDEAD0, 1'b0, 2'd0);
        look("ctr1", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);
        train(32'h100, 32'hDEAD0, 1'b0, 2'd0);
        look("ctr0", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);
        train(32'h100, 32'hDEAD0, 1'b0, 2'd0);
        look("ctr0_floor", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);
        train(32'h100, 32'h200, 1'b1, 2'd0);
        look("ctr1_up", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);
        train(32'h100, 32'h200, 1'b1, 2'd0);
        look("ctr2_up", 32'h100, 1'b1, 1'b1, 32'h200, 2'd0);
        train(32'h100, 32'h200, 1'b1, 2'd0);
        train(32'h100, 32'h200, 1'b1, 2'd0);
        train(32'h100, 32'hDEAD0, 1'b0, 2'd0);
        look("sat_then_dec", 32'h100, 1'b1, 1'b1, 32'h200, 2'd0);
        train(32'h100, 32'hDEAD0, 1'b0, 2'd0);
        look("sat_dec_twice", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);

        // Untaken miss never allocates.
        train(32'h300, 32'h3000, 1'b0, 2'd0);
        look("no_alloc", 32'h300, 1'b0, 1'b0, 32'h304, 2'd0);
        look("still_there", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);

        // Alias at index 0 replaces the 0x100 entry.
        train(32'h200, 32'h880, 1'b1, 2'd1);
        look("alias_evicted", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
        look("alias_jump", 32'h200, 1'b1, 1'b1, 32'h880, 2'd1);
        train(32'h200, 32'h0, 1'b0, 2'd0);
        look("alias_ctr2_dec", 32'h200, 1'b1, 1'b0, 32'h204, 2'd0);

        // Return entry sourced from the RAS when it has something.
        train(32'h500, 32'h40, 1'b1, 2'd2);
        ras_empty = 1'b0; ras_address = 32'h1234;
        look("ret_ras", 32'h500, 1'b1, 1'b1, 32'h1234, 2'd2);
        ras_empty = 1'b1;
        look("ret_empty", 32'h500, 1'b1, 1'b1, 32'h40, 2'd2);

        // Same-cycle lookup and update: no bypass.
        update_valid = 1'b1; update_pc = 32'h600; update_target = 32'h7000;
        update_taken = 1'b1; update_type = 2'd1;
        look("same_cycle", 32'h600, 1'b0, 1'b0, 32'h604, 2'd0);
        @(posedge clk); #1;
        update_valid = 1'b0;
        look("next_cycle", 32'h600, 1'b1, 1'b1, 32'h7000, 2'd1);

        // Reset coinciding with an update wins and clears everything.
        reset = 1'b0;
        update_valid = 1'b1; update_pc = 32'h900; update_target = 32'h9990;
        update_taken = 1'b1; update_type = 2'd1;
        look("reset_gates", 32'h600, 1'b0, 1'b0, 32'h604, 2'd0);
        @(posedge clk); #1;
        reset = 1'b1; update_valid = 1'b0;
        look("reset_drop_upd", 32'h900, 1'b0, 1'b0, 32'h904, 2'd0);
        look("reset_cleared", 32'h600, 1'b0, 1'b0, 32'h604, 2'd0);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
